// File: rtl/wb_commit_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_commit_arbiter_pkg : shared widths and the buffered writeback entry type
// Rev 1.0
// ---------------------------------------------------------------------------
package wb_commit_arbiter_pkg;

  localparam int WIDTH = 32;
  localparam int RS    = 5;

  typedef struct packed {
    logic [RS-1:0]    rd;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] pc;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_commit_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_commit_arbiter_if : Branch and Memory lane valid/ready result handshakes
// Rev 1.0
// ---------------------------------------------------------------------------
interface wb_commit_arbiter_if;

  logic                                  br_valid;
  logic                                  br_ready;
  logic [wb_commit_arbiter_pkg::RS-1:0]    br_rd;
  logic [wb_commit_arbiter_pkg::WIDTH-1:0] br_wd;
  logic [wb_commit_arbiter_pkg::WIDTH-1:0] br_pc;

  logic                                  mem_valid;
  logic                                  mem_ready;
  logic [wb_commit_arbiter_pkg::RS-1:0]    mem_rd;
  logic [wb_commit_arbiter_pkg::WIDTH-1:0] mem_wd;
  logic [wb_commit_arbiter_pkg::WIDTH-1:0] mem_pc;

  modport master (
    output br_valid, br_rd, br_wd, br_pc,
    output mem_valid, mem_rd, mem_wd, mem_pc,
    input  br_ready, mem_ready
  );

  modport slave (
    input  br_valid, br_rd, br_wd, br_pc,
    input  mem_valid, mem_rd, mem_wd, mem_pc,
    output br_ready, mem_ready
  );

endinterface
`default_nettype wire

// File: rtl/wb_commit_arbiter_lane_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_lane_fifo : per-lane synchronous FIFO of writeback entries, registered ready
// Rev 1.0
// ---------------------------------------------------------------------------
module wb_lane_fifo
  import wb_commit_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic flush,
  input  wire logic push,
  input  wb_entry_t push_data,
  input  wire logic pop,
  output wb_entry_t head,
  output logic      empty,
  output logic      full,
  output logic      ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] C_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] C_ONE  = (PTR_W+1)'(1);

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [PTR_W:0]   w_count_nxt;
  logic             r_ready;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == C_FULL);
  assign ready     = r_ready;
  assign head      = r_mem[r_rd_ptr];
  assign w_do_push = push && (!full || pop) && !flush;
  assign w_do_pop  = pop && !empty && !flush;

  always_comb begin
    w_count_nxt = r_count;
    if (flush) begin
      w_count_nxt = '0;
    end else if (w_do_push && !w_do_pop) begin
      w_count_nxt = r_count + C_ONE;
    end else if (w_do_pop && !w_do_push) begin
      w_count_nxt = r_count - C_ONE;
    end
  end

  // Pointers are log2(DEPTH) wide, so wrap is the natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != C_FULL);
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/wb_commit_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_commit_arbiter : buffers Branch/Memory results, serialises same-rd writes
// Rev 1.0
// ---------------------------------------------------------------------------
module wb_commit_arbiter
  import wb_commit_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  wire logic           clk,
  input  wire logic           rst,
  input  wire logic           flush,
  wb_commit_arbiter_if.slave  lanes,
  output logic [RS-1:0]       rd_Branch,
  output logic [WIDTH-1:0]    wd_Branch,
  output logic [WIDTH-1:0]    PC_out_Branch,
  output logic [RS-1:0]       rd_Memory,
  output logic [WIDTH-1:0]    wd_Memory,
  output logic [WIDTH-1:0]    PC_out_Memory,
  output logic [1:0]          write_en,
  output logic [CNT_W-1:0]    conflict_cnt
);

  wb_entry_t w_br_in, w_mem_in, w_br_head, w_mem_head;
  logic w_br_empty, w_br_full, w_mem_empty, w_mem_full;
  logic w_br_push, w_mem_push, w_pop_br, w_pop_mem, w_conflict;
  logic w_same_rd, w_mem_older;

  logic [RS-1:0]    r_rd_br,  r_rd_mem;
  logic [WIDTH-1:0] r_wd_br,  r_wd_mem;
  logic [WIDTH-1:0] r_pc_br,  r_pc_mem;
  logic [1:0]       r_we;
  logic [CNT_W-1:0] r_cnt;

  assign w_br_in    = '{rd: lanes.br_rd,  wd: lanes.br_wd,  pc: lanes.br_pc};
  assign w_mem_in   = '{rd: lanes.mem_rd, wd: lanes.mem_wd, pc: lanes.mem_pc};
  assign w_br_push  = lanes.br_valid  && lanes.br_ready;
  assign w_mem_push = lanes.mem_valid && lanes.mem_ready;

  wb_lane_fifo #(.DEPTH(FIFO_DEPTH)) u_br_fifo (
    .clk(clk), .rst(rst), .flush(flush),
    .push(w_br_push), .push_data(w_br_in), .pop(w_pop_br),
    .head(w_br_head), .empty(w_br_empty), .full(w_br_full), .ready(lanes.br_ready)
  );

  wb_lane_fifo #(.DEPTH(FIFO_DEPTH)) u_mem_fifo (
    .clk(clk), .rst(rst), .flush(flush),
    .push(w_mem_push), .push_data(w_mem_in), .pop(w_pop_mem),
    .head(w_mem_head), .empty(w_mem_empty), .full(w_mem_full), .ready(lanes.mem_ready)
  );

  // rd==0 writes are discarded by the RF, so they never need serialising.
  assign w_same_rd   = !w_br_empty && !w_mem_empty &&
                       (w_br_head.rd == w_mem_head.rd) && (w_br_head.rd != '0);
  assign w_mem_older = (w_mem_head.pc <= w_br_head.pc);

  always_comb begin
    w_pop_br   = 1'b0;
    w_pop_mem  = 1'b0;
    w_conflict = 1'b0;
    if (!flush) begin
      if (w_same_rd) begin
        w_conflict = 1'b1;
        w_pop_mem  = w_mem_older;
        w_pop_br   = !w_mem_older;
      end else begin
        w_pop_br  = !w_br_empty;
        w_pop_mem = !w_mem_empty;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_br  <= '0;
      r_wd_br  <= '0;
      r_pc_br  <= '0;
      r_rd_mem <= '0;
      r_wd_mem <= '0;
      r_pc_mem <= '0;
      r_we     <= 2'b00;
      r_cnt    <= '0;
    end else begin
      r_we <= {w_pop_mem && (w_mem_head.rd != '0), w_pop_br && (w_br_head.rd != '0)};
      if (w_pop_br) begin
        r_rd_br <= w_br_head.rd;
        r_wd_br <= w_br_head.wd;
        r_pc_br <= w_br_head.pc;
      end
      if (w_pop_mem) begin
        r_rd_mem <= w_mem_head.rd;
        r_wd_mem <= w_mem_head.wd;
        r_pc_mem <= w_mem_head.pc;
      end
      if (w_conflict && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign rd_Branch     = r_rd_br;
  assign wd_Branch     = r_wd_br;
  assign PC_out_Branch = r_pc_br;
  assign rd_Memory     = r_rd_mem;
  assign wd_Memory     = r_wd_mem;
  assign PC_out_Memory = r_pc_mem;
  assign write_en      = r_we;
  assign conflict_cnt  = r_cnt;

  a_no_equal_pc: assert property (@(posedge clk) disable iff (rst)
    !(w_same_rd && (w_br_head.pc == w_mem_head.pc)));
  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !((w_br_push && w_br_full) || (w_mem_push && w_mem_full)));

endmodule
`default_nettype wire
